// File: rtl/multi_nco_pwm.sv
// Multi-voice NCO mixer: per-channel phase accumulators with waveform and gain,
// summed with saturation once per PWM frame and played out as PWM audio.
module multi_nco_pwm #(
  parameter int CHANNELS = 4,
  parameter int PHASE_W  = 16,
  parameter int OUT_W    = 8,
  parameter int GAIN_W   = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PHASE_W-1:0]  cfg_freq,
  input  logic [1:0]          cfg_mode,
  input  logic [GAIN_W-1:0]   cfg_gain,
  input  logic [CHANNELS-1:0] enable_mask,
  output logic [OUT_W-1:0]    sample,
  output logic                sample_tick,
  output logic                AUD_PWM,
  output logic                AUD_SD
);

  localparam int ACC_W  = OUT_W + $clog2(CHANNELS) + 1;
  localparam int PROD_W = OUT_W + GAIN_W;
  localparam logic [OUT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   sample_q, sample_d;
  logic [OUT_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [OUT_W-1:0]   duty_q, duty_d;
  logic               tick_q, tick_d;
  logic               pwm_q, pwm_d;
  logic               sd_q, sd_d;

  logic [PHASE_W-1:0] phase_arr [CHANNELS];
  logic [1:0]         mode_arr  [CHANNELS];
  logic [GAIN_W-1:0]  gain_arr  [CHANNELS];

  // Per-channel configuration and phase; phase advances only when this channel is mixed.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] freq_q, freq_d;
    logic [1:0]         mode_q, mode_d;
    logic [GAIN_W-1:0]  gain_q, gain_d;

    always_comb begin
      freq_d  = freq_q;
      mode_d  = mode_q;
      gain_d  = gain_q;
      phase_d = phase_q;
      if (cfg_wr && (cfg_ch == CH_W'(gi))) begin
        freq_d = cfg_freq;
        mode_d = cfg_mode;
        gain_d = cfg_gain;
      end
      if ((state_q == ACCUM) && (ch_q == CH_W'(gi))) begin
        phase_d = phase_q + freq_q;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        phase_q <= '0;
        freq_q  <= '0;
        mode_q  <= '0;
        gain_q  <= '0;
      end else begin
        phase_q <= phase_d;
        freq_q  <= freq_d;
        mode_q  <= mode_d;
        gain_q  <= gain_d;
      end
    end

    assign phase_arr[gi] = phase_q;
    assign mode_arr[gi]  = mode_q;
    assign gain_arr[gi]  = gain_q;
  end

  // Waveform and gain for the channel currently selected by ch_q.
  logic [OUT_W-1:0]  p;
  logic [OUT_W-1:0]  p_dbl;
  logic [OUT_W-1:0]  wave;
  logic [GAIN_W:0]   gain_p1;
  logic [PROD_W-1:0] prod;
  logic [OUT_W-1:0]  scaled;
  logic [ACC_W-1:0]  acc_sum;

  always_comb begin
    p       = OUT_W'(phase_arr[ch_q] >> (PHASE_W - OUT_W));
    p_dbl   = OUT_W'(p << 1);
    wave    = '0;
    case (mode_arr[ch_q])
      2'd0:    wave = p;
      2'd1:    wave = {OUT_W{p[OUT_W-1]}};
      2'd2:    wave = p[OUT_W-1] ? ~p_dbl : p_dbl;
      default: wave = '0;
    endcase
    gain_p1 = {1'b0, gain_arr[ch_q]} + 1'b1;
    prod    = PROD_W'(wave) * PROD_W'(gain_p1);
    scaled  = OUT_W'(prod >> GAIN_W);
    acc_sum = acc_q + (enable_mask[ch_q] ? ACC_W'(scaled) : '0);
  end

  // Frame sequencer: one channel per clock, sample committed with the last channel.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    case (state_q)
      IDLE: begin
        if (pwm_cnt_q == '0) begin
          state_d = ACCUM;
          ch_d    = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          state_d  = LATCH;
          sample_d = (acc_sum > ACC_W'(CNT_MAX)) ? CNT_MAX : OUT_W'(acc_sum);
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      LATCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    tick_d    = (pwm_cnt_q == CNT_MAX);
    duty_d    = (pwm_cnt_q == CNT_MAX) ? sample_q : duty_q;
    pwm_d     = (pwm_cnt_q < duty_q);
    sd_d      = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      tick_q    <= 1'b0;
      pwm_q     <= 1'b0;
      sd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      tick_q    <= tick_d;
      pwm_q     <= pwm_d;
      sd_q      <= sd_d;
    end
  end

  assign sample      = sample_q;
  assign sample_tick = tick_q;
  assign AUD_PWM     = pwm_q;
  assign AUD_SD      = sd_q;

endmodule

// File: tb/tb_multi_nco_pwm.sv
// Bench for multi_nco_pwm: frame-level reference model compared every cycle,
// plus directed waveform/PWM cases with hand-computed expectations.
module tb_multi_nco_pwm;
  localparam int NCH  = 3;
  localparam int PW   = 16;
  localparam int OW   = 8;
  localparam int GW   = 4;
  localparam int CW   = 2;
  localparam int FULL = (1 << OW) - 1;
  localparam int HALF = 1 << (OW - 1);

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cfg_wr = 1'b0;
  logic [CW-1:0]  cfg_ch = '0;
  logic [PW-1:0]  cfg_freq = '0;
  logic [1:0]     cfg_mode = '0;
  logic [GW-1:0]  cfg_gain = '0;
  logic [NCH-1:0] enable_mask = '0;
  logic [OW-1:0]  sample;
  logic           sample_tick;
  logic           aud_pwm;
  logic           aud_sd;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  multi_nco_pwm #(
    .CHANNELS(NCH), .PHASE_W(PW), .OUT_W(OW), .GAIN_W(GW)
  ) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_freq(cfg_freq), .cfg_mode(cfg_mode), .cfg_gain(cfg_gain),
    .enable_mask(enable_mask), .sample(sample), .sample_tick(sample_tick),
    .AUD_PWM(aud_pwm), .AUD_SD(aud_sd)
  );

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position k (1..NCH) mixes channel k-1 using the phase
  // before its advance; sample is saturated after the last channel.
  function automatic int wave_of(input int mode, input int p);
    case (mode)
      0:       return p;
      1:       return (p >= HALF) ? FULL : 0;
      2:       return (p < HALF) ? 2 * p : (2 * FULL + 1) - 2 * p;
      default: return 0;
    endcase
  endfunction

  int m_phase [NCH];
  int m_freq  [NCH];
  int m_mode  [NCH];
  int m_gain  [NCH];
  int m_cnt = 0, m_acc = 0, m_sample = 0, m_duty = 0;
  int m_pwm = 0, m_tick = 0, m_sd = 0;

  always @(posedge clk or negedge reset) begin
    int c;
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_phase[i] = 0; m_freq[i] = 0; m_mode[i] = 0; m_gain[i] = 0;
      end
      m_cnt = 0; m_acc = 0; m_sample = 0; m_duty = 0;
      m_pwm = 0; m_tick = 0; m_sd = 0;
    end else begin
      m_sd  = 1;
      m_pwm = (m_cnt < m_duty) ? 1 : 0;
      if (m_cnt >= 1 && m_cnt <= NCH) begin
        c = m_cnt - 1;
        if (c == 0) m_acc = 0;
        if (enable_mask[c])
          m_acc += (wave_of(m_mode[c], m_phase[c] >> (PW - OW)) * (m_gain[c] + 1)) >> GW;
        m_phase[c] = (m_phase[c] + m_freq[c]) & ((1 << PW) - 1);
        if (c == NCH - 1) m_sample = (m_acc > FULL) ? FULL : m_acc;
      end
      if (m_cnt == FULL) m_duty = m_sample;
      if (cfg_wr && (int'(cfg_ch) < NCH)) begin
        m_freq[cfg_ch] = int'(cfg_freq);
        m_mode[cfg_ch] = int'(cfg_mode);
        m_gain[cfg_ch] = int'(cfg_gain);
      end
      m_tick = (m_cnt == FULL) ? 1 : 0;
      m_cnt  = (m_cnt + 1) & FULL;
    end
  end

  always @(negedge clk) begin
    check("sample", sample, m_sample);
    check("sample_tick", sample_tick, m_tick);
    check("aud_pwm", aud_pwm, m_pwm);
    check("aud_sd", aud_sd, m_sd);
    if (reset && m_tick == 1)
      $display("frame: sample=%0d duty=%0d", sample, m_duty);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
    cyc += n;
  endtask

  task automatic restart();
    cfg_wr = 1'b0;
    reset  = 1'b0;
    tick(2);
    reset  = 1'b1;
    cyc    = 0;
  endtask

  task automatic cfg(input int ch, input int f, input int m, input int g);
    cfg_wr   = 1'b1;
    cfg_ch   = CW'(ch);
    cfg_freq = PW'(f);
    cfg_mode = 2'(m);
    cfg_gain = GW'(g);
    tick(1);
    cfg_wr   = 1'b0;
  endtask

  // Sample of frame k is committed on edge NCH+1 of that frame.
  task automatic frame_sample(input string name, input int k, input int exp);
    tick(NCH + 1 + 256 * k - cyc);
    check(name, sample, exp);
  endtask

  task automatic pwm_count(input string name, input int start, input int exp);
    int hi;
    hi = 0;
    tick(start - cyc);
    for (int i = 0; i < 256; i++) begin
      if (aud_pwm === 1'b1) hi++;
      tick(1);
    end
    check(name, hi, exp);
  endtask

  int t3_exp [4] = '{0, 255, 0, 255};
  int t4_exp [3] = '{0, 32, 64};
  int t5_exp [9] = '{0, 64, 128, 192, 255, 191, 127, 63, 0};

  initial begin
    // T1: inputs toggle while held in reset
    tick(1);
    for (int i = 0; i < 8; i++) begin
      cfg_wr = 1'b1; cfg_ch = CW'($urandom); cfg_freq = PW'($urandom);
      cfg_mode = 2'($urandom); cfg_gain = GW'($urandom); enable_mask = NCH'($urandom);
      tick(1);
    end
    check("t1_sample", sample, 0);
    check("t1_pwm", aud_pwm, 0);
    check("t1_tick", sample_tick, 0);
    check("t1_sd_held", aud_sd, 0);
    cfg_wr = 1'b0;
    reset  = 1'b1;
    cyc    = 0;
    check("t1_sd_release", aud_sd, 0);
    tick(1);
    check("t1_sd_on", aud_sd, 1);

    // T2: ch0 saw, ramps one code per frame
    restart();
    enable_mask = 3'b001;
    cfg(0, 16'h0100, 0, 15);
    for (int k = 0; k < 4; k++) frame_sample("t2_saw", k, k);

    // T3: all channels square, sum saturates
    restart();
    enable_mask = 3'b111;
    for (int c = 0; c < NCH; c++) cfg(c, 16'h8000, 1, 15);
    for (int k = 0; k < 2; k++) frame_sample("t3_square", k, t3_exp[k]);
    pwm_count("t3_pwm_full", 512, 255);
    pwm_count("t3_pwm_zero", 768, 0);
    check("t3_sample_f3", sample, t3_exp[3]);

    // T4: saw at half gain, PWM duty 64
    restart();
    enable_mask = 3'b001;
    cfg(0, 16'h4000, 0, 7);
    for (int k = 0; k < 3; k++) frame_sample("t4_saw_half", k, t4_exp[k]);
    pwm_count("t4_pwm_64", 768, 64);
    frame_sample("t4_wrap", 4, 0);

    // T5: triangle
    restart();
    enable_mask = 3'b001;
    cfg(0, 16'h2000, 2, 15);
    for (int k = 0; k < 9; k++) frame_sample("t5_tri", k, t5_exp[k]);

    // T6: out-of-range channel write, then reset in mid-accumulation
    restart();
    enable_mask = 3'b001;
    cfg(0, 16'h4000, 0, 15);
    cfg(3, 16'h1234, 1, 15);
    frame_sample("t6_ignored_f0", 0, 0);
    frame_sample("t6_ignored_f1", 1, 64);
    tick(514 - cyc);
    reset = 1'b0;
    #1;
    check("t6_rst_sample", sample, 0);
    check("t6_rst_sd", aud_sd, 0);
    tick(3);
    reset = 1'b1;
    cyc   = 0;
    frame_sample("t6_post_reset", 0, 0);

    // Randomized configuration traffic, mask changes and one reset pulse
    restart();
    enable_mask = NCH'($urandom);
    for (int i = 0; i < 40 * 256; i++) begin
      if ($urandom_range(7) == 0) begin
        cfg_wr   = 1'b1;
        cfg_ch   = CW'($urandom_range(3));
        cfg_freq = PW'($urandom);
        cfg_mode = 2'($urandom);
        cfg_gain = GW'($urandom);
      end else begin
        cfg_wr = 1'b0;
      end
      if ($urandom_range(63) == 0) enable_mask = NCH'($urandom);
      reset = (i >= 5000 && i < 5002) ? 1'b0 : 1'b1;
      tick(1);
    end
    cfg_wr = 1'b0;
    tick(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
